// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state type and sizing helpers for the push-button conditioner
package button_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DB,
    PRESSED,
    REPEATING,
    RELEASE_DB
  } btn_state_e;

  function automatic int tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // The ms counter only ever holds values up to max-1 before wrapping to 0.
  function automatic int cnt_width(input int debounce_ms, input int hold_ms, input int repeat_ms);
    int m;
    m = debounce_ms;
    if (hold_ms > m) m = hold_ms;
    if (repeat_ms > m) m = repeat_ms;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: 2-flop synchroniser, debounce/hold/repeat FSM and ms counter
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int CW          = cnt_width(DEBOUNCE_MS, HOLD_MS, REPEAT_MS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_n,
  input  logic tick,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] RPT_END  = CW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, press_q, press_d;
  logic          release_q, release_d, repeat_q, repeat_d;

  // An input change is tested before the tick so it wins over a terminal count.
  always_comb begin
    sync1_d   = ~btn_raw_n;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == DB_END) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == HOLD_END) begin
            state_d  = REPEATING;
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPEATING: begin
        if (!sync2_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (tick && (REPEAT_MS > 0)) begin
          if (cnt_q == RPT_END) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        // A return to pressed keeps the level high and restarts the hold timer.
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == DB_END) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - shared 1 ms tick plus N_BTN independent button channels
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int            DIV       = tick_div(CLK_HZ);
  localparam int            TW        = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_raw_n  (btn_raw_n[i]),
      .tick       (tick),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule
